// File: rtl/loop_nest_ctrl.sv
// loop_nest_ctrl
//   Walks a configured nest of counted loops and emits one control pulse per
//   cycle telling downstream address generators what happened: a new walk
//   began (loop_init), a level was entered (loop_enter), a level's counter
//   stepped (loop_index_valid), a level finished (loop_exit), or the whole
//   walk completed (loop_ctrl_done).
//
// Ports
//   clk              single clock, all state updates on the rising edge
//   reset            asynchronous, active-high
//   cfg_loop_iter_v  append one loop level (only honoured while idle)
//   cfg_loop_iter    iterations minus one for the appended level
//   start            pulse to begin walking the configured nest
//   stall            freezes the walk and suppresses pulses (not in DONE)
//   busy             high from INIT through DONE inclusive
//   loop_index       loop level qualified by the pulse outputs, 0 otherwise
//   loop_index_valid counter of loop_index stepped
//   loop_init        walk starting, downstream clears its offsets
//   loop_enter       loop_index entered
//   loop_exit        loop_index finished
//   loop_ctrl_done   one-cycle pulse at the end of the walk
module loop_nest_ctrl #(
  parameter int LOOP_ID_W   = 5,
  parameter int LOOP_ITER_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_loop_iter_v,
  input  logic [LOOP_ITER_W-1:0] cfg_loop_iter,
  input  logic                   start,
  input  logic                   stall,
  output logic                   busy,
  output logic [LOOP_ID_W-1:0]   loop_index,
  output logic                   loop_index_valid,
  output logic                   loop_init,
  output logic                   loop_enter,
  output logic                   loop_exit,
  output logic                   loop_ctrl_done
);

  localparam int DEPTH = 1 << LOOP_ID_W;

  localparam logic [LOOP_ID_W:0]     NUM_ONE = 1;
  localparam logic [LOOP_ID_W-1:0]   LVL_ONE = 1;
  localparam logic [LOOP_ITER_W-1:0] CNT_ONE = 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_ENTER,
    S_STEP,
    S_DONE
  } state_t;

  state_t state;
  state_t state_nxt;

  // num_loops is one bit wider than a level index so a full nest of
  // 2^LOOP_ID_W levels is representable; its MSB doubles as the full flag.
  logic [LOOP_ID_W:0]     num_loops;
  logic [LOOP_ID_W-1:0]   level;
  logic [LOOP_ITER_W-1:0] cnt      [DEPTH];
  logic [LOOP_ITER_W-1:0] max_iter [DEPTH];

  logic last_level;
  logic cnt_at_max;
  logic cfg_we;
  logic clr_all;
  logic cnt_inc;
  logic cnt_clr;
  logic lvl_up;
  logic lvl_down;

  assign last_level = ({1'b0, level} == (num_loops - NUM_ONE));
  // Equality (not overflow) ends a level, so max = all-ones runs the full
  // 2^LOOP_ITER_W range without the counter ever wrapping.
  assign cnt_at_max = (cnt[level] == max_iter[level]);
  assign cfg_we     = (state == S_IDLE) && cfg_loop_iter_v && !num_loops[LOOP_ID_W];
  assign busy       = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Pulses are decodes of the registered state and counters; stall only
  // gates them and blocks every state/datapath update.
  always_comb begin
    state_nxt        = state;
    loop_index       = '0;
    loop_init        = 1'b0;
    loop_enter       = 1'b0;
    loop_index_valid = 1'b0;
    loop_exit        = 1'b0;
    loop_ctrl_done   = 1'b0;
    clr_all          = 1'b0;
    cnt_inc          = 1'b0;
    cnt_clr          = 1'b0;
    lvl_up           = 1'b0;
    lvl_down         = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (num_loops != '0) ? S_INIT : S_DONE;
        end
      end
      S_INIT: begin
        if (!stall) begin
          loop_init = 1'b1;
          clr_all   = 1'b1;
          state_nxt = S_ENTER;
        end
      end
      S_ENTER: begin
        if (!stall) begin
          loop_enter = 1'b1;
          loop_index = level;
          if (!last_level) begin
            lvl_up = 1'b1;
          end else begin
            state_nxt = S_STEP;
          end
        end
      end
      S_STEP: begin
        if (!stall) begin
          loop_index = level;
          if (!cnt_at_max) begin
            loop_index_valid = 1'b1;
            cnt_inc          = 1'b1;
            // Stepping an outer level re-enters everything beneath it.
            if (!last_level) begin
              lvl_up    = 1'b1;
              state_nxt = S_ENTER;
            end
          end else begin
            loop_exit = 1'b1;
            cnt_clr   = 1'b1;
            if (level == '0) begin
              state_nxt = S_DONE;
            end else begin
              lvl_down = 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        loop_ctrl_done = 1'b1;
        state_nxt      = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Configuration table, level pointer and per-level counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      num_loops <= '0;
      level     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        cnt[i]      <= '0;
        max_iter[i] <= '0;
      end
    end else begin
      if (cfg_we) begin
        max_iter[num_loops[LOOP_ID_W-1:0]] <= cfg_loop_iter;
        num_loops                          <= num_loops + NUM_ONE;
      end
      if (clr_all) begin
        level <= '0;
        for (int i = 0; i < DEPTH; i++) begin
          cnt[i] <= '0;
        end
      end
      if (cnt_inc) begin
        cnt[level] <= cnt[level] + CNT_ONE;
      end
      if (cnt_clr) begin
        cnt[level] <= '0;
      end
      if (lvl_up) begin
        level <= level + LVL_ONE;
      end
      if (lvl_down) begin
        level <= level - LVL_ONE;
      end
    end
  end

endmodule

// File: tb/tb_loop_nest_ctrl.sv
// tb_loop_nest_ctrl
//   Bench for loop_nest_ctrl: fixed per-cycle vector tables for the named
//   corner cases, plus randomized nests with random stall and config noise
//   checked cycle by cycle against a pulse-sequence model built from the
//   odometer view of the nest.
module tb_loop_nest_ctrl;

  localparam int IDW = 5;
  localparam int ITW = 16;

  localparam int K_NONE  = 0;
  localparam int K_INIT  = 1;
  localparam int K_ENTER = 2;
  localparam int K_VALID = 3;
  localparam int K_EXIT  = 4;
  localparam int K_DONE  = 5;
  localparam int K_MULTI = 7;

  logic           clk = 1'b0;
  logic           reset;
  logic           cfg_loop_iter_v;
  logic [ITW-1:0] cfg_loop_iter;
  logic           start;
  logic           stall;
  logic           busy;
  logic [IDW-1:0] loop_index;
  logic           loop_index_valid;
  logic           loop_init;
  logic           loop_enter;
  logic           loop_exit;
  logic           loop_ctrl_done;

  loop_nest_ctrl #(
    .LOOP_ID_W  (IDW),
    .LOOP_ITER_W(ITW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_loop_iter_v (cfg_loop_iter_v),
    .cfg_loop_iter   (cfg_loop_iter),
    .start           (start),
    .stall           (stall),
    .busy            (busy),
    .loop_index      (loop_index),
    .loop_index_valid(loop_index_valid),
    .loop_init       (loop_init),
    .loop_enter      (loop_enter),
    .loop_exit       (loop_exit),
    .loop_ctrl_done  (loop_ctrl_done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic stall;
    int   kind;
    int   idx;
    logic busy;
  } vec_t;

  vec_t tbl[$];
  int   mcfg[$];   // configuration the DUT should currently hold
  int   expq[$];   // expected pulse codes for one walk

  // Pulse code = kind*256 + loop_index; several pulses at once -> K_MULTI.
  function automatic int code_now();
    int n;
    int k;
    n = int'(loop_init) + int'(loop_enter) + int'(loop_index_valid) +
        int'(loop_exit) + int'(loop_ctrl_done);
    if (n > 1)                 k = K_MULTI;
    else if (loop_init)        k = K_INIT;
    else if (loop_enter)       k = K_ENTER;
    else if (loop_index_valid) k = K_VALID;
    else if (loop_exit)        k = K_EXIT;
    else if (loop_ctrl_done)   k = K_DONE;
    else                       k = K_NONE;
    return k * 256 + int'(loop_index);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  task automatic add_v(input logic s, input int k, input int i, input logic b);
    vec_t v;
    v.stall = s;
    v.kind  = k;
    v.idx   = i;
    v.busy  = b;
    tbl.push_back(v);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset           = 1'b1;
    cfg_loop_iter_v = 1'b0;
    cfg_loop_iter   = '0;
    start           = 1'b0;
    stall           = 1'b0;
    #1;
    check("reset_pulses", code_now(), 0);
    check("reset_busy", int'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    mcfg.delete();
  endtask

  task automatic cfg_write(input int v);
    @(negedge clk);
    cfg_loop_iter_v = 1'b1;
    cfg_loop_iter   = ITW'(v);
    @(negedge clk);
    cfg_loop_iter_v = 1'b0;
    if (mcfg.size() < 32) mcfg.push_back(v);
  endtask

  // Returns at the falling edge that opens the first cycle after start.
  task automatic start_pulse();
    @(negedge clk);
    stall           = 1'b0;
    cfg_loop_iter_v = 1'b0;
    start           = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic apply_table(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      if (i > 0) @(negedge clk);
      stall = tbl[i].stall;
      #1;
      check(name, code_now(), tbl[i].kind * 256 + tbl[i].idx);
      check({name, "_busy"}, int'(busy), int'(tbl[i].busy));
    end
    stall = 1'b0;
  endtask

  // Two-level nest with max = {1, 2}; optional stall burst before entry at.
  task automatic build_walk_a(input int at, input int len);
    int seq[13];
    seq = '{K_INIT*256, K_ENTER*256, K_ENTER*256+1, K_VALID*256+1,
            K_VALID*256+1, K_EXIT*256+1, K_VALID*256, K_ENTER*256+1,
            K_VALID*256+1, K_VALID*256+1, K_EXIT*256+1, K_EXIT*256,
            K_DONE*256};
    tbl.delete();
    for (int i = 0; i < 13; i++) begin
      if (i == at) begin
        for (int s = 0; s < len; s++) add_v(1'b1, K_NONE, 0, 1'b1);
      end
      add_v(1'b0, seq[i] / 256, seq[i] % 256, 1'b1);
    end
    add_v(1'b0, K_NONE, 0, 1'b0);
  endtask

  // Odometer view of the nest: the innermost level steps max times, then
  // the lowest outer digit that has not reached its max advances and every
  // level beneath it is entered afresh.
  task automatic build_expected();
    int n;
    int l;
    int idx[32];
    n = mcfg.size();
    expq.delete();
    if (n == 0) begin
      expq.push_back(K_DONE * 256);
      return;
    end
    expq.push_back(K_INIT * 256);
    for (int j = 0; j < n; j++) begin
      expq.push_back(K_ENTER * 256 + j);
      idx[j] = 0;
    end
    while (1) begin
      for (int v = 0; v < mcfg[n-1]; v++) expq.push_back(K_VALID * 256 + n - 1);
      expq.push_back(K_EXIT * 256 + n - 1);
      l = n - 2;
      while (l >= 0 && idx[l] == mcfg[l]) begin
        expq.push_back(K_EXIT * 256 + l);
        l--;
      end
      if (l < 0) break;
      expq.push_back(K_VALID * 256 + l);
      idx[l]++;
      for (int j = l + 1; j < n; j++) begin
        expq.push_back(K_ENTER * 256 + j);
        idx[j] = 0;
      end
    end
    expq.push_back(K_DONE * 256);
  endtask

  // Every unstalled cycle of a walk carries the next pulse; a stalled cycle
  // carries none, except that DONE goes out regardless of stall.
  task automatic run_walk(input string name, input int stall_pct, input bit noise);
    int pos;
    int cyc;
    int exp;
    pos = 0;
    cyc = 0;
    build_expected();
    start_pulse();
    while (pos < expq.size() && cyc < 20000) begin
      if (cyc > 0) @(negedge clk);
      stall           = (int'($urandom_range(99)) < stall_pct);
      cfg_loop_iter_v = noise ? 1'($urandom_range(1)) : 1'b0;
      cfg_loop_iter   = ITW'($urandom);
      #1;
      cyc++;
      if (stall && expq[pos] != K_DONE * 256) begin
        exp = 0;
      end else begin
        exp = expq[pos];
        pos++;
      end
      check(name, code_now(), exp);
      check({name, "_busy"}, int'(busy), 1);
    end
    check({name, "_complete"}, pos, expq.size());
    @(negedge clk);
    stall           = 1'b0;
    cfg_loop_iter_v = 1'b0;
    #1;
    check({name, "_idle"}, code_now(), 0);
    check({name, "_idle_busy"}, int'(busy), 0);
  endtask

  initial begin
    int n;
    reset           = 1'b1;
    cfg_loop_iter_v = 1'b0;
    cfg_loop_iter   = '0;
    start           = 1'b0;
    stall           = 1'b0;
    do_reset();

    // Empty nest: DONE one cycle after start and nothing else.
    tbl.delete();
    add_v(1'b0, K_DONE, 0, 1'b1);
    add_v(1'b0, K_NONE, 0, 1'b0);
    add_v(1'b0, K_NONE, 0, 1'b0);
    start_pulse();
    apply_table("empty_nest", tbl.size());

    // Two-level reference walk, then the same config again with a stall.
    cfg_write(1);
    cfg_write(2);
    build_walk_a(-1, 0);
    start_pulse();
    apply_table("walk_1_2", tbl.size());
    build_walk_a(3, 3);
    start_pulse();
    apply_table("walk_1_2_stall", tbl.size());

    // Reset in the second ENTER1, then a fresh single-level config.
    build_walk_a(-1, 0);
    start_pulse();
    apply_table("walk_pre_reset", 8);
    #1 reset = 1'b1;
    #1;
    check("midwalk_reset_pulses", code_now(), 0);
    check("midwalk_reset_busy", int'(busy), 0);
    @(negedge clk);
    reset = 1'b0;
    mcfg.delete();
    cfg_write(0);
    tbl.delete();
    add_v(1'b0, K_INIT, 0, 1'b1);
    add_v(1'b0, K_ENTER, 0, 1'b1);
    add_v(1'b0, K_EXIT, 0, 1'b1);
    add_v(1'b0, K_DONE, 0, 1'b1);
    add_v(1'b0, K_NONE, 0, 1'b0);
    start_pulse();
    apply_table("single_zero", tbl.size());

    // Full table: 33rd write dropped; writes while busy have no effect.
    do_reset();
    for (int i = 0; i < 32; i++) cfg_write(0);
    cfg_write(3);
    run_walk("full_nest_noise", 20, 1'b1);
    run_walk("full_nest_repeat", 0, 1'b0);

    // Random nests with random stall and config noise while busy.
    for (int t = 0; t < 8; t++) begin
      if (t % 2 == 0) begin
        do_reset();
        n = int'($urandom_range(3));
      end else begin
        n = int'($urandom_range(1));
      end
      for (int i = 0; i < n; i++) cfg_write(int'($urandom_range(2)));
      run_walk("random_walk", 25, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/loop_nest_ctrl.md
LOOP_NEST_CTRL -- requirements
Module: loop_nest_ctrl

Interface
REQ-001 SHALL have parameter LOOP_ID_W, default 5, giving loop index width; max nest depth is 2^LOOP_ID_W.
REQ-002 SHALL have parameter LOOP_ITER_W, default 16, giving the per-loop iteration config width.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cfg_loop_iter_v  input  1  append one loop config.
REQ-006 SHALL have port cfg_loop_iter  input  LOOP_ITER_W  iterations minus one (0 means 1 iteration).
REQ-007 SHALL have port start  input  1  single-cycle pulse to begin walking the configured nest.
REQ-008 SHALL have port stall  input  1  downstream backpressure; freezes the walk.
REQ-009 SHALL have port busy  output  1  high from INIT through DONE inclusive.
REQ-010 SHALL have port loop_index  output  LOOP_ID_W  loop level qualified by the pulses below.
REQ-011 SHALL have port loop_index_valid  output  1  counter of loop_index incremented (stride step).
REQ-012 SHALL have port loop_init  output  1  start of a walk; downstream resets offsets.
REQ-013 SHALL have port loop_enter  output  1  loop_index entered.
REQ-014 SHALL have port loop_exit  output  1  loop_index finished.
REQ-015 SHALL have port loop_ctrl_done  output  1  one-cycle pulse at end of walk.

Function
REQ-016 SHALL hold states IDLE, INIT, ENTER, STEP, DONE, plus num_loops, current level, and one LOOP_ITER_W counter and one LOOP_ITER_W max register per level.
REQ-017 SHALL, in IDLE only, store cfg_loop_iter into max[num_loops] and increment num_loops on cfg_loop_iter_v; level 0 is outermost; writes outside IDLE or with num_loops at 2^LOOP_ID_W are ignored.
REQ-018 SHALL, on start in IDLE with num_loops>0, enter INIT next cycle; with num_loops==0, enter DONE next cycle; start outside IDLE is ignored.
REQ-019 SHALL, in INIT, drive loop_init=1 and loop_index=0, clear all counters and set level=0, then go to ENTER.
REQ-020 SHALL, in ENTER, drive loop_enter=1 with loop_index=level; if level<num_loops-1, increment level and stay; else go to STEP.
REQ-021 SHALL, in STEP with counter[level]<max[level], drive loop_index_valid=1 with loop_index=level and increment counter[level]; if level<num_loops-1, increment level and go to ENTER; else stay in STEP.
REQ-022 SHALL, in STEP with counter[level]==max[level], drive loop_exit=1 with loop_index=level and clear counter[level]; if level==0, go to DONE; else decrement level and stay in STEP.
REQ-023 SHALL, in DONE, drive loop_ctrl_done=1 for exactly one cycle and return to IDLE; DONE ignores stall.
REQ-024 SHALL, while stall=1 in INIT, ENTER or STEP, drive all pulse outputs 0 and hold state, level and counters unchanged.
REQ-025 SHALL drive at most one of loop_init, loop_enter, loop_index_valid, loop_exit, loop_ctrl_done in any cycle; all pulses are registered-state decodes with no combinational path from stall to pulses beyond gating.
REQ-026 SHALL compare before incrementing so max=all-ones yields 2^LOOP_ITER_W iterations without overflow.
REQ-027 SHALL retain num_loops and max[] after DONE so a new start repeats the same walk.
REQ-028 SHALL drive loop_index=0 when no pulse is active.

Reset
REQ-029 SHALL, on reset assertion at any time including mid-walk, immediately force IDLE, clear num_loops, level, all counters and max[], and drive busy and all pulse outputs to 0.
REQ-030 SHALL resume in IDLE accepting config on the first edge after reset deasserts.

Verification
REQ-031 SHALL cover the case cfg 1 then 2, start at edge k, stall=0 -> pulse sequence INIT0, ENTER0, ENTER1, V1, V1, EXIT1, V0, ENTER1, V1, V1, EXIT1, EXIT0, DONE on cycles k+1..k+13.
REQ-032 SHALL cover the case single loop with cfg 0 -> INIT, ENTER0, EXIT0, DONE, with no loop_index_valid.
REQ-033 SHALL cover start with num_loops==0 -> loop_ctrl_done exactly one cycle after start, with no other pulses.
REQ-034 SHALL cover stall held 3 cycles during the first V1 of REQ-031 -> identical sequence delayed by 3 cycles, with no pulses while stalled.
REQ-035 SHALL cover reset asserted during the second ENTER1, then cfg 0 and start -> walk of REQ-032, with stale config gone.
REQ-036 SHALL cover 32 cfg writes plus a 33rd -> num_loops=32 and the 33rd ignored; cfg_loop_iter_v while busy has no effect on the walk.
